// File: rtl/uart_word_sender.sv
// uart_word_sender: buffers 32-bit words in a small FIFO and streams them
// to a byte-wide UART transmitter, optionally prefixing each word with a sync byte.
module uart_word_sender #(
    parameter int         DEPTH     = 4,
    parameter int         SYNC_EN   = 1,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     word_valid,
    input  logic [31:0]              word_data,
    output logic                     word_ready,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    input  logic                     tx_busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     sender_busy,
    output logic [15:0]              words_sent
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [2:0]  LAST = (SYNC_EN != 0) ? 3'd4 : 3'd3;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] SEND = 3'd2;
    localparam logic [2:0] GAP  = 3'd3;
    localparam logic [2:0] WAIT = 3'd4;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic [2:0]    r_state;
    logic [31:0]   r_hold;
    logic [2:0]    r_idx;
    logic [7:0]    r_tx_data;
    logic [15:0]   r_words_sent;

    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_head;

    // Byte idx of a word: optional sync byte first, then MSB-first data.
    function automatic logic [7:0] pick(input logic [31:0] w,
                                        input logic [2:0]  idx);
        logic [2:0] p;
        p = (SYNC_EN != 0) ? idx - 3'd1 : idx;
        if ((SYNC_EN != 0) && (idx == 3'd0)) begin
            pick = SYNC_BYTE;
        end else begin
            case (p)
                3'd0:    pick = w[31:24];
                3'd1:    pick = w[23:16];
                3'd2:    pick = w[15:8];
                3'd3:    pick = w[7:0];
                default: pick = 8'h00;
            endcase
        end
    endfunction

    assign word_ready  = (r_count != FULL);
    assign w_push      = word_valid && word_ready;
    assign w_pop       = (r_state == LOAD) && (r_count != '0);
    assign w_head      = r_mem[r_rd_ptr];
    assign tx_start    = (r_state == SEND) && !tx_busy;
    assign tx_data     = r_tx_data;
    assign fifo_count  = r_count;
    assign sender_busy = (r_state != IDLE) || (r_count != '0);
    assign words_sent  = r_words_sent;

    // FIFO storage write; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= word_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Byte sequencer: pop a word, then hand each byte to the transmitter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_hold       <= '0;
            r_idx        <= '0;
            r_tx_data    <= 8'h00;
            r_words_sent <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_count != '0) begin
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    if (w_pop) begin
                        r_hold    <= w_head;
                        r_idx     <= 3'd0;
                        r_tx_data <= pick(w_head, 3'd0);
                        r_state   <= SEND;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        r_state <= GAP;
                    end
                end
                GAP: begin
                    // Transmitter raises busy one cycle after start.
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (!tx_busy) begin
                        if (r_idx < LAST) begin
                            r_idx     <= r_idx + 3'd1;
                            r_tx_data <= pick(r_hold, r_idx + 3'd1);
                            r_state   <= SEND;
                        end else begin
                            r_words_sent <= r_words_sent + 16'd1;
                            r_state      <= (r_count != '0) ? LOAD : IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
